// File: rtl/uart_pkg.sv
// Shared UART TX types: sequencer state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int START_BITS = 1;
  localparam int BCNT_W     = 4;

  // Index of the final DATA cycle; the parity bit rides as a ninth data bit.
  function automatic logic [BCNT_W-1:0] data_last(input logic par_en);
    data_last = par_en ? BCNT_W'(DATA_BITS) : BCNT_W'(DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, power-of-two depth, synchronous active-high reset.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART TX frame sequencer: buffers bytes and frames them around an external
// bit-serialising datapath (start, 8 data, optional parity, 1 or 2 stops).
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [7:0]                      tx_data,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_stop2,
  output logic                            dp_load,
  output logic [7:0]                      dp_data,
  output logic                            dp_parity_en,
  input  logic                            dp_tx_out,
  output logic                            tx_serial,
  output logic                            busy,
  output logic                            frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  tx_state_e         state_q, state_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [7:0]        hold_q, hold_d;
  logic              par_q, par_d;
  logic              stop2_q, stop2_d;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic              start_frame;

  assign tx_ready     = !fifo_full;
  assign fifo_push    = tx_valid && tx_ready;
  assign busy         = (state_q != ST_IDLE);
  assign dp_data      = hold_q;
  assign dp_parity_en = par_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    hold_d      = hold_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    tx_serial   = 1'b1;
    dp_load     = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        tx_serial = 1'b0;
        dp_load   = 1'b1;
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        tx_serial = dp_tx_out;
        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        if (bit_cnt_q == data_last(par_q)) begin
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (stop_cnt_q == stop2_q) begin
          frame_done = 1'b1;
          if (!fifo_empty) start_frame = 1'b1;
          else             state_d     = ST_IDLE;
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
    endcase

    // Frame config is sampled only here, so mid-frame cfg edits wait a frame.
    if (start_frame) begin
      fifo_pop = 1'b1;
      hold_d   = fifo_dout;
      par_d    = cfg_parity_en;
      stop2_d  = cfg_stop2;
      state_d  = ST_START;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      hold_q     <= '0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      hold_q     <= hold_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed + randomized bench; expected line waveform built per frame from bytes/cfg.
module tb_uart_tx_sequencer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          cfg_parity_en;
  logic          cfg_stop2;
  logic          dp_load;
  logic [7:0]    dp_data;
  logic          dp_parity_en;
  logic          dp_tx_out;
  logic          tx_serial;
  logic          busy;
  logic          frame_done;
  logic [LW-1:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  uart_tx_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .cfg_parity_en (cfg_parity_en),
    .cfg_stop2     (cfg_stop2),
    .dp_load       (dp_load),
    .dp_data       (dp_data),
    .dp_parity_en  (dp_parity_en),
    .dp_tx_out     (dp_tx_out),
    .tx_serial     (tx_serial),
    .busy          (busy),
    .frame_done    (frame_done),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: LSB-first shift of the loaded byte, then even parity.
  logic [8:0] dp_sh  = '0;
  logic [3:0] dp_idx = '0;
  always @(posedge clk) begin
    if (dp_load) begin
      dp_sh  <= {^dp_data, dp_data};
      dp_idx <= '0;
    end else if (dp_idx < 4'd8) begin
      dp_idx <= dp_idx + 4'd1;
    end
  end
  assign dp_tx_out = dp_sh[dp_idx];

  typedef struct packed {
    bit       line;
    bit       bsy;
    bit       done;
    bit       load;
    bit       chk_dp;
    bit [7:0] data;
    bit       par;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("tx_serial", 32'(tx_serial), 32'(cur.line));
      chk("busy", 32'(busy), 32'(cur.bsy));
      chk("frame_done", 32'(frame_done), 32'(cur.done));
      chk("dp_load", 32'(dp_load), 32'(cur.load));
      if (cur.chk_dp) begin
        chk("dp_data", 32'(dp_data), 32'(cur.data));
        chk("dp_parity_en", 32'(dp_parity_en), 32'(cur.par));
      end
    end
  end

  task automatic add_idle(input int n);
    exp_t e;
    e = '{line: 1'b1, bsy: 1'b0, done: 1'b0, load: 1'b0,
          chk_dp: 1'b0, data: 8'h00, par: 1'b0};
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic add_frame(input logic [7:0] b, input bit par, input bit s2);
    exp_t e;
    e = '{line: 1'b0, bsy: 1'b1, done: 1'b0, load: 1'b1,
          chk_dp: 1'b1, data: b, par: par};
    exp_q.push_back(e);
    e.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e.line = b[i];
      exp_q.push_back(e);
    end
    if (par) begin
      e.line = ^b;
      exp_q.push_back(e);
    end
    e.line = 1'b1;
    if (s2) exp_q.push_back(e);
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  function automatic int flen(input bit par, input bit s2);
    return 10 + int'(par) + int'(s2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $error("FAIL %s drain timeout observed=%0d expected=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [7:0] b [4];
    bit p, s;
    int sz, n;

    reset         = 1'b1;
    tx_valid      = 1'b0;
    tx_data       = '0;
    cfg_parity_en = 1'b0;
    cfg_stop2     = 1'b0;
    repeat (2) tick();

    chk("rst_tx_serial", 32'(tx_serial), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_dp_load", 32'(dp_load), 32'd0);
    chk("rst_dp_data", 32'(dp_data), 32'd0);
    chk("rst_dp_parity_en", 32'(dp_parity_en), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    tick();

    // 0xA5, no parity, one stop
    add_idle(2);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_idle(2);
    push(8'hA5);
    wait_drain("a5_frame");

    // 0x3C, parity, two stops
    cfg_parity_en = 1'b1;
    cfg_stop2     = 1'b1;
    add_idle(2);
    add_frame(8'h3C, 1'b1, 1'b1);
    add_idle(2);
    push(8'h3C);
    wait_drain("3c_frame");

    // five pushes back-to-back, FIFO fills to four
    p = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    cfg_parity_en = p;
    cfg_stop2     = s;
    add_idle(2);
    for (int i = 1; i <= 5; i++) add_frame(8'(i), p, s);
    add_idle(2);
    for (int i = 1; i <= 5; i++) begin
      chk("burst_tx_ready_pre", 32'(tx_ready), 32'd1);
      push(8'(i));
    end
    chk("burst_level_full", 32'(fifo_level), 32'd4);
    chk("burst_tx_ready_full", 32'(tx_ready), 32'd0);
    wait_drain("burst_order");

    // parity toggled mid-frame only affects the following frame
    p = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    b[0] = 8'($urandom);
    b[1] = 8'($urandom);
    cfg_parity_en = p;
    cfg_stop2     = s;
    add_idle(2);
    add_frame(b[0], p, s);
    add_frame(b[1], !p, s);
    add_idle(2);
    push(b[0]);
    push(b[1]);
    repeat (3) tick();
    cfg_parity_en = !p;
    wait_drain("cfg_toggle");

    // reset during the fourth DATA cycle
    p = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    b[0] = 8'($urandom);
    b[1] = 8'($urandom);
    cfg_parity_en = p;
    cfg_stop2     = s;
    add_idle(2);
    sz = exp_q.size();
    add_frame(b[0], p, s);
    while (exp_q.size() > sz + 5) void'(exp_q.pop_back());
    add_idle(6);
    push(b[0]);
    push(b[1]);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("midrst_fifo_level", 32'(fifo_level), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_dp_data", 32'(dp_data), 32'd0);
    chk("midrst_dp_parity_en", 32'(dp_parity_en), 32'd0);
    reset = 1'b0;
    wait_drain("midframe_reset");

    // simultaneous push and pop at level 2
    p = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    cfg_parity_en = p;
    cfg_stop2     = s;
    add_idle(2);
    for (int i = 0; i < 4; i++) add_frame(b[i], p, s);
    add_idle(2);
    push(b[0]);
    push(b[1]);
    push(b[2]);
    chk("pp_level_before", 32'(fifo_level), 32'd2);
    repeat (flen(p, s) - 2) tick();
    chk("pp_level_at_pop", 32'(fifo_level), 32'd2);
    push(b[3]);
    chk("pp_level_after", 32'(fifo_level), 32'd2);
    wait_drain("push_pop_order");

    // random short bursts with random config
    for (int k = 0; k < 4; k++) begin
      p = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) b[i] = 8'($urandom);
      cfg_parity_en = p;
      cfg_stop2     = s;
      add_idle(2);
      for (int i = 0; i < n; i++) add_frame(b[i], p, s);
      add_idle(2);
      for (int i = 0; i < n; i++) push(b[i]);
      wait_drain("random_burst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered bytes (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port tx_valid, input, 1, upstream byte valid.
REQ-005 SHALL have port tx_ready, output, 1, the FIFO can accept a byte.
REQ-006 SHALL have port tx_data, input, 8, upstream byte.
REQ-007 SHALL have port cfg_parity_en, input, 1, insert parity bit in next frame.
REQ-008 SHALL have port cfg_stop2, input, 1, send two stop bits instead of one.
REQ-009 SHALL have port dp_load, output, 1, load strobe to the TX datapath.
REQ-010 SHALL have port dp_data, output, 8, byte presented to the datapath.
REQ-011 SHALL have port dp_parity_en, output, 1, parity enable to the datapath.
REQ-012 SHALL have port dp_tx_out, input, 1, serial bit from the datapath.
REQ-013 SHALL have port tx_serial, output, 1, framed UART line (idle high).
REQ-014 SHALL have port busy, output, 1, a frame is in progress.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse on the last stop-bit cycle.
REQ-016 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH+1), bytes currently buffered.

Function
REQ-017 SHALL accept a byte into the FIFO on any cycle with tx_valid and tx_ready high; tx_ready = (fifo_level != FIFO_DEPTH).
REQ-018 SHALL run FSM states IDLE, START, DATA, STOP; bit period is one clk.
REQ-019 SHALL in IDLE drive tx_serial high, busy low, and move to START when fifo_level > 0.
REQ-020 SHALL on the IDLE->START edge pop the FIFO head into a holding register and latch cfg_parity_en and cfg_stop2 for the whole frame.
REQ-021 SHALL in START (exactly 1 cycle) drive tx_serial low and assert dp_load, with dp_data and dp_parity_en taken from the holding/latched values.
REQ-022 SHALL in DATA drive tx_serial = dp_tx_out for 8 cycles, or 9 when the latched parity_en is 1, counted by an internal bit counter.
REQ-023 SHALL in STOP drive tx_serial high for 1 cycle, or 2 when the latched stop2 is 1, and pulse frame_done on the final STOP cycle.
REQ-024 SHALL go from the final STOP cycle directly to START (with pop) when the FIFO is non-empty, else to IDLE; back-to-back frames have no idle gap.
REQ-025 SHALL keep dp_load low outside START, and keep dp_data/dp_parity_en stable from START until the frame ends.
REQ-026 SHALL update fifo_level correctly on a simultaneous push and pop (level unchanged); a push into a full FIFO is impossible because tx_ready is low.
REQ-027 SHALL give frame length = 1 + 8 + parity + stop bits cycles: 10, 11, 11, or 12.
REQ-028 SHALL ignore cfg_* changes during a frame; they take effect at the next pop.

Reset
REQ-029 SHALL on reset, including mid-frame, enter IDLE on the next edge: tx_serial=1, busy=0, frame_done=0, dp_load=0, dp_data=0, dp_parity_en=0, fifo_level=0, tx_ready=1, FIFO pointers and bit counter cleared.
REQ-030 SHALL discard a partially sent frame on reset, with no further bits emitted.

Structure
REQ-031 SHALL place the FSM state enum and the frame-length constants (DATA_BITS=8) in a shared package uart_pkg.
REQ-032 SHALL implement the FIFO as one sub-module, sync_fifo (parameter DEPTH, WIDTH=8, push/pop/full/empty/level).

Verification
REQ-033 SHALL verify single byte 0xA5, parity off, stop1: tx_serial is low 1 cycle, then 8 datapath bits, then high 1 cycle; frame_done pulses at cycle 10 after START; busy spans 10 cycles.
REQ-034 SHALL verify 0x3C with parity on and stop2: DATA lasts 9 cycles, STOP lasts 2, frame is 12 cycles, and dp_parity_en=1 throughout.
REQ-035 SHALL verify 5 pushes of 0x01..0x05 with FIFO_DEPTH=4 and no drain stall: tx_ready drops when level=4; frames are sent back-to-back with no idle cycle, in order 0x01..0x05.
REQ-036 SHALL verify toggling cfg_parity_en mid-frame: the current frame is unchanged and the next frame uses the new value.
REQ-037 SHALL verify reset asserted in the 4th DATA cycle: the next cycle has tx_serial=1, fifo_level=0, busy=0, and no frame_done.
REQ-038 SHALL verify push and pop in the same cycle at level 2: level stays 2 and byte order is preserved.
